// File: rtl/piano_key_reader_if.sv
// Piano key reader MMIO bundle: raw keys and read strobe in,
// read word, debounced levels and pending flag out.
interface piano_key_reader_if #(
    parameter int NUM_KEYS = 8
);
    logic [NUM_KEYS-1:0] iPianoKeys;
    logic                iDoPianoRead;
    logic [15:0]         oPianoReadData;
    logic [NUM_KEYS-1:0] oPianoKeyHeld;
    logic                oPianoEventPending;

    modport master (
        output iPianoKeys,
        output iDoPianoRead,
        input  oPianoReadData,
        input  oPianoKeyHeld,
        input  oPianoEventPending
    );

    modport slave (
        input  iPianoKeys,
        input  iDoPianoRead,
        output oPianoReadData,
        output oPianoKeyHeld,
        output oPianoEventPending
    );
endinterface

// File: rtl/piano_key_reader.sv
// Piano key reader: sync + debounce per key, press/release events
// queued in a FIFO and popped by the memorio read strobe.
module piano_key_reader #(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic              iCpuClock,
    input  logic              iCpuReset,
    piano_key_reader_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] sync1, sync2, held, pend, dir;
    logic [CW-1:0]       cnt [NUM_KEYS];

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;

    logic [NUM_KEYS-1:0] sel_mask;
    logic [4:0]          sel_idx;
    logic [7:0]          evt;
    logic push, pop, wr_en, drop, empty, full;

    // lowest pending key wins the single push slot this cycle
    assign sel_mask = pend & (~pend + 1'b1);

    always_comb begin
        sel_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pend[k]) begin
                sel_idx = 5'(k);
            end
        end
    end

    assign evt   = {|(dir & sel_mask), 2'b00, sel_idx};
    assign empty = (count == '0);
    assign full  = (count == DEPTH);
    assign push  = |pend;
    assign pop   = bus.iDoPianoRead && !empty;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge iCpuClock) begin
        if (iCpuReset) begin
            sync1    <= '0;
            sync2    <= '0;
            held     <= '0;
            pend     <= '0;
            dir      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1 <= bus.iPianoKeys;
            sync2 <= sync1;
            pend  <= pend & ~sel_mask;
            // a new level is accepted on the differing edge after the
            // counter has already seen DEBOUNCE_CYCLES of them
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync2[k] != held[k]) begin
                    if (cnt[k] == DB_MAX) begin
                        held[k] <= sync2[k];
                        dir[k]  <= sync2[k];
                        pend[k] <= 1'b1;
                        cnt[k]  <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.iDoPianoRead) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCpuClock) begin
        if (!iCpuReset && wr_en) begin
            mem[wr_ptr] <= evt;
        end
    end

    assign bus.oPianoReadData     = {!empty, overflow, 6'(count),
                                     empty ? 8'h00 : mem[rd_ptr]};
    assign bus.oPianoKeyHeld      = held;
    assign bus.oPianoEventPending = !empty;
endmodule

// File: tb/tb_piano_key_reader.sv
// Bench for piano_key_reader: read-strobe scoreboard plus directed
// status checks, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, NUM_KEYS=8.
module tb_piano_key_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_data [$];
    string       sb_name [$];

    piano_key_reader_if #(.NUM_KEYS(8)) bus ();

    piano_key_reader #(
        .NUM_KEYS(8),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .iCpuClock(clk),
        .iCpuReset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // monitor: every read strobe presents the head word, checked
    // against the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && bus.iDoPianoRead) begin
            checks++;
            if (sb_data.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected got=%h", bus.oPianoReadData);
            end else begin
                logic [15:0] e;
                string       n;
                e = sb_data.pop_front();
                n = sb_name.pop_front();
                if (bus.oPianoReadData !== e) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h", n, bus.oPianoReadData, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [15:0] exp);
        sb_data.push_back(exp);
        sb_name.push_back(name);
        bus.iDoPianoRead = 1'b1;
        tick(1);
        bus.iDoPianoRead = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic status(input string name, input logic [15:0] rdata,
                          input logic [7:0] held_exp, input logic pend_exp);
        chk({name, "_data"}, 32'(bus.oPianoReadData), 32'(rdata));
        chk({name, "_held"}, 32'(bus.oPianoKeyHeld), 32'(held_exp));
        chk({name, "_pend"}, 32'(bus.oPianoEventPending), 32'(pend_exp));
    endtask

    initial begin
        bus.iPianoKeys   = 8'h00;
        bus.iDoPianoRead = 1'b0;
        tick(2);
        status("reset", 16'h0000, 8'h00, 1'b0);
        rst = 1'b0;

        // key 3 press: held flips at edge 6, event readable after edge 7
        bus.iPianoKeys = 8'h08;
        tick(6);
        status("k3_e5", 16'h0000, 8'h00, 1'b0);
        tick(1);
        status("k3_e6", 16'h0000, 8'h08, 1'b0);
        tick(1);
        status("k3_e7", 16'h8183, 8'h08, 1'b1);
        rd("k3_read", 16'h8183);
        rd("empty_read", 16'h0000);
        status("k3_after", 16'h0000, 8'h08, 1'b0);

        // short glitch on key 5 is ignored
        bus.iPianoKeys = 8'h28;
        tick(3);
        bus.iPianoKeys = 8'h08;
        tick(10);
        status("glitch", 16'h0000, 8'h08, 1'b0);

        // release key 3
        bus.iPianoKeys = 8'h00;
        tick(8);
        rd("k3_release", 16'h8103);

        // keys 1 and 6 together: two events, lower index first
        bus.iPianoKeys = 8'h42;
        tick(8);
        status("k16_e7", 16'h8181, 8'h42, 1'b1);
        tick(1);
        status("k16_e8", 16'h8281, 8'h42, 1'b1);
        rd("k16_first", 16'h8281);
        rd("k16_second", 16'h8186);
        bus.iPianoKeys = 8'h00;
        tick(9);
        rd("k16_rel1", 16'h8201);
        rd("k16_rel6", 16'h8106);

        // six presses, never read: four queued, two dropped
        bus.iPianoKeys = 8'h3F;
        tick(13);
        status("ovf", 16'hC480, 8'h3F, 1'b1);
        rd("ovf_read", 16'hC480);
        status("ovf_clear", 16'h8381, 8'h3F, 1'b1);

        // fill to four, then push and pop on the same edge
        bus.iPianoKeys = 8'h3C;
        tick(8);
        status("full", 16'h8481, 8'h3C, 1'b1);
        rd("full_rw", 16'h8481);
        status("full_after", 16'h8482, 8'h3C, 1'b1);
        rd("drain0", 16'h8482);
        rd("drain1", 16'h8383);
        rd("drain2", 16'h8200);
        rd("drain3", 16'h8101);
        rd("drain_empty", 16'h0000);

        // reset in the middle of debouncing leaves nothing behind
        bus.iPianoKeys = 8'h80;
        tick(4);
        rst = 1'b1;
        bus.iPianoKeys = 8'h00;
        tick(1);
        status("midrst", 16'h0000, 8'h00, 1'b0);
        rst = 1'b0;
        tick(12);
        status("post_rst", 16'h0000, 8'h00, 1'b0);

        tick(2);
        chk("sb_drained", 32'(sb_data.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
